pipe_hazard_ctrl: RTL and testbench

//   Parametrised hazard and forwarding controller for the pipelined CPU. It sits beside the ID-stage decoder.
//   - Keeps a shift-register scoreboard of in-flight register writes for FWD_STAGES stages past ID.
//   - Picks the forwarding source for each operand, or stalls ID/IF when data is not yet available.
//   - Load latency is configurable.
//   - Adds a structural interlock for a multi-cycle mul/div unit (MDU) and a branch-flush input.

---
 rtl/pipe_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard/forwarding controller. It scoreboards the in-flight
//               register writes, picks the forwarding sources and stalls
//               ID/IF for load-use hazards and when the MDU is busy.
//               Defining HAZ_STATS_EN adds the stall_cnt and stats_clr ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
  parameter  int REG_AW     = 5,
  parameter  int FWD_STAGES = 3,
  parameter  int LOAD_LAT   = 1,
  parameter  int MDU_LAT    = 4,
  localparam int FW         = $clog2(FWD_STAGES + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wreg,
  input  logic [REG_AW-1:0] id_rn,
  input  logic              id_load,
  input  logic              id_mdu,
  input  logic              flush,
`ifdef HAZ_STATS_EN
  input  logic              stats_clr,
  output logic [31:0]       stall_cnt,
`endif
  output logic              wpcir,
  output logic              id_issue,
  output logic [FW-1:0]     fwda,
  output logic [FW-1:0]     fwdb,
  output logic              mdu_busy
);

  localparam int CW = $clog2(MDU_LAT + 1);

  logic              v_q  [FWD_STAGES];
  logic [REG_AW-1:0] rn_q [FWD_STAGES];
  logic              ld_q [FWD_STAGES];
  logic [CW-1:0]     mdu_cnt_q, mdu_cnt_d;
  logic              avail [FWD_STAGES];
  logic              raw_a, raw_b, mdu_stall, stall;

  always_comb begin
    for (int k = 0; k < FWD_STAGES; k++)
      avail[k] = v_q[k] & (~ld_q[k] | (k >= LOAD_LAT));
  end

  // Walk from the oldest stage to the youngest so that the lowest k wins.
  always_comb begin
    fwda  = '0;
    fwdb  = '0;
    raw_a = 1'b0;
    raw_b = 1'b0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (id_use_rs && (id_rs != '0) && v_q[k] && (rn_q[k] == id_rs)) begin
        fwda  = avail[k] ? FW'(k + 1) : '0;
        raw_a = ~avail[k];
      end
      if (id_use_rt && (id_rt != '0) && v_q[k] && (rn_q[k] == id_rt)) begin
        fwdb  = avail[k] ? FW'(k + 1) : '0;
        raw_b = ~avail[k];
      end
    end
  end

  assign mdu_busy  = (mdu_cnt_q != '0);
  assign mdu_stall = id_valid & id_mdu & mdu_busy;
  assign stall     = id_valid & ~flush & (raw_a | raw_b | mdu_stall);
  assign wpcir     = ~stall;
  assign id_issue  = id_valid & ~flush & ~stall;

  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (id_issue && id_mdu)
      mdu_cnt_d = CW'(MDU_LAT);
    else if (mdu_cnt_q != '0)
      mdu_cnt_d = mdu_cnt_q - CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mdu_cnt_q <= '0;
      for (int k = 0; k < FWD_STAGES; k++) begin
        v_q[k]  <= 1'b0;
        rn_q[k] <= '0;
        ld_q[k] <= 1'b0;
      end
    end else begin
      mdu_cnt_q <= mdu_cnt_d;
      v_q[0]    <= id_issue & id_wreg & (id_rn != '0);
      rn_q[0]   <= id_rn;
      ld_q[0]   <= id_load;
      for (int k = 1; k < FWD_STAGES; k++) begin
        v_q[k]  <= v_q[k-1];
        rn_q[k] <= rn_q[k-1];
        ld_q[k] <= ld_q[k-1];
      end
    end
  end

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stats_clr)
      stall_cnt_d = '0;
    else if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench for pipe_hazard_ctrl using the
//               default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rs, id_use_rt, id_wreg, id_load, id_mdu, flush;
  logic [4:0] id_rs, id_rt, id_rn;
  logic       wpcir, id_issue, mdu_busy;
  logic [1:0] fwda, fwdb;
`ifdef HAZ_STATS_EN
  logic        stats_clr;
  logic [31:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_STAGES(3), .LOAD_LAT(1), .MDU_LAT(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_wreg   (id_wreg),
    .id_rn     (id_rn),
    .id_load   (id_load),
    .id_mdu    (id_mdu),
    .flush     (flush),
`ifdef HAZ_STATS_EN
    .stats_clr (stats_clr),
    .stall_cnt (stall_cnt),
`endif
    .wpcir     (wpcir),
    .id_issue  (id_issue),
    .fwda      (fwda),
    .fwdb      (fwdb),
    .mdu_busy  (mdu_busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt, input logic wr,
                        input logic [4:0] rn, input logic ld, input logic md);
    id_valid = v;  id_rs = rs;  id_use_rs = urs;  id_rt = rt;  id_use_rt = urt;
    id_wreg  = wr; id_rn = rn;  id_load   = ld;   id_mdu = md;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    flush = 1'b0;
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
`ifdef HAZ_STATS_EN
    stats_clr = 1'b0;
`endif
    #1;
    chk("rst_wpcir", wpcir, 1);
    chk("rst_fwda", fwda, 0);
    chk("rst_fwdb", fwdb, 0);
    chk("rst_busy", mdu_busy, 0);
    step();
    step();
    reset = 1'b0;
    step();

    // Test 1: ALU result forwarded from EX, MEM, then WB
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    #1 chk("t1_add_issue", id_issue, 1);
    step();
    set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    #1 chk("t1_wpcir", wpcir, 1);
    chk("t1_fwda1", fwda, 1);
    chk("t1_fwdb0", fwdb, 0);
    step();
    chk("t1_fwda2", fwda, 2);
    step();
    chk("t1_fwda3", fwda, 3);
    step();
    idle();
    #1 chk("t1_drained", fwda, 0);
    step();

    // Test 2: load-use stalls one cycle, then forwards from MEM
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
    #1 chk("t2_stall_wpcir", wpcir, 0);
    chk("t2_stall_fwdb", fwdb, 0);
    chk("t2_stall_issue", id_issue, 0);
    step();
    chk("t2_go_issue", id_issue, 1);
    chk("t2_go_fwdb", fwdb, 2);
    chk("t2_go_wpcir", wpcir, 1);
    step();
    idle();
    step(); step(); step();

    // Test 3: register 0 never forwards nor stalls
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    #1 chk("t3_fwda", fwda, 0);
    chk("t3_fwdb", fwdb, 0);
    chk("t3_wpcir", wpcir, 1);
    step();
    idle();
    step(); step(); step();

    // Test 5: flush overrides the load-use stall; the killed op is not scoreboarded
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    flush = 1'b1;
    #1 chk("t5_wpcir", wpcir, 1);
    chk("t5_issue", id_issue, 0);
    step();
    flush = 1'b0;
    set_id(1'b1, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    #1 chk("t5_killed_fwda", fwda, 0);
    chk("t5_lw_fwdb", fwdb, 2);
    chk("t5_after_wpcir", wpcir, 1);
    step();
    idle();
    step(); step(); step();

    // Test 4: back-to-back MDU ops
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1 chk("t4_first_issue", id_issue, 1);
    chk("t4_busy_before", mdu_busy, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_stall%0d", i), wpcir, 0);
      step();
    end
    chk("t4_second_issue", id_issue, 1);
    chk("t4_second_wpcir", wpcir, 1);
    step();
    idle();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_busy%0d", i), mdu_busy, 1);
      step();
    end
    chk("t4_busy_done", mdu_busy, 0);
    step();

    // Test 6: asynchronous reset in the middle of an MDU stall
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    step();
    chk("t6_stall_a", wpcir, 0);
    step();
    chk("t6_stall_b", wpcir, 0);
`ifdef HAZ_STATS_EN
    chk("t6_cnt_pre", stall_cnt, 6);
`endif
    #2 reset = 1'b1;
    #1 chk("t6_busy", mdu_busy, 0);
    chk("t6_wpcir", wpcir, 1);
`ifdef HAZ_STATS_EN
    chk("t6_cnt", stall_cnt, 0);
`endif
    idle();
    step();
    reset = 1'b0;
    step();
    chk("t6_post_busy", mdu_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
